// File: rtl/ppu_pkg.sv
// Shared PPU definitions: element width default, max-pool FSM states and
// the signed/unsigned greater-than helper used by every pooling lane.
package ppu_pkg;

    localparam int DATA_W = 8;

    // Operand width for the compare helper. Any element width up to this fits.
    localparam int GT_W = 64;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_e;

    // Strict a > b for zero-extended operands whose real width is 'width'.
    // Flipping the element sign bit turns a two's-complement order into an
    // unsigned one, so a single unsigned compare serves both modes.
    function automatic logic greater(
        input logic [GT_W-1:0] a,
        input logic [GT_W-1:0] b,
        input logic            is_signed,
        input int              width
    );
        logic [GT_W-1:0] flip;
        flip = '0;
        if (is_signed) begin
            flip[width-1] = 1'b1;
        end
        return (a ^ flip) > (b ^ flip);
    endfunction

endpackage

// File: rtl/maxpool_accum_qint_lane.sv
// One pooling lane: running-max register plus the compare that feeds it.
// 'result' is the lane maximum including the beat currently on din, so the
// top can load it straight into out_data on the last beat of a window.
// With MAXPOOL_RELU_EN defined, negative signed maxima are clamped to zero.
module maxpool_lane
    import ppu_pkg::*;
#(
    parameter int DATA_W = ppu_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              update,
    input  logic              first,
    input  logic              is_signed,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] result
);

    logic [DATA_W-1:0] max_q;
    logic [DATA_W-1:0] winner;
    logic              din_wins;

    // Pick the larger of stored max and incoming element; ties keep the store.
    always_comb begin
        din_wins = greater(GT_W'(din), GT_W'(max_q), is_signed, DATA_W);
        winner   = (first || din_wins) ? din : max_q;
`ifdef MAXPOOL_RELU_EN
        result   = (is_signed && winner[DATA_W-1]) ? '0 : winner;
`else
        result   = winner;
`endif
    end

    // Max register: loaded by the first beat of a window, raised by later ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            max_q <= '0;
        end else if (load) begin
            max_q <= din;
        end else if (update && din_wins) begin
            max_q <= din;
        end
    end

endmodule

// File: rtl/maxpool_accum_qint.sv
// Multi-lane window max-pool accumulator. Collects cfg_win_len input beats,
// keeps a per-lane maximum and emits one packed result beat per window.
// Optional build macro: MAXPOOL_RELU_EN (fused ReLU on signed results).
//
// Handshake: a beat moves on a stream when its valid and ready are both high
// at a rising clk edge; valid never depends on ready, while in_ready is
// !out_valid || out_ready and so follows out_ready combinationally.
module maxpool_accum_qint
    import ppu_pkg::*;
#(
    parameter int DATA_W  = ppu_pkg::DATA_W,
    parameter int LANES   = 4,
    parameter int WIN_MAX = 16,
    parameter int CNT_W   = $clog2(WIN_MAX + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [CNT_W-1:0]        cfg_win_len,
    input  logic                    cfg_signed,
    input  logic                    abort,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [LANES*DATA_W-1:0] in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [LANES*DATA_W-1:0] out_data,
    output logic                    busy
);

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        count_q, count_d;
    logic [CNT_W-1:0]        len_q, len_d;
    logic                    sgn_q, sgn_d;
    logic [CNT_W-1:0]        len_norm;
    logic                    accept, take, finish;
    logic                    lane_load, lane_update, lane_first, lane_signed;
    logic                    out_valid_d;
    logic [LANES*DATA_W-1:0] out_data_d;
    logic [LANES*DATA_W-1:0] lane_result;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign take     = out_valid && out_ready;
    assign busy     = (state_q == ACCUM);

    // Window length as used: zero means one beat, oversize clamps to WIN_MAX.
    always_comb begin
        if (cfg_win_len == '0) begin
            len_norm = CNT_W'(1);
        end else if (cfg_win_len > CNT_W'(WIN_MAX)) begin
            len_norm = CNT_W'(WIN_MAX);
        end else begin
            len_norm = cfg_win_len;
        end
    end

    // Next-state, counter, lane controls and output-register updates.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        len_d       = len_q;
        sgn_d       = sgn_q;
        lane_load   = 1'b0;
        lane_update = 1'b0;
        lane_first  = (state_q == IDLE);
        lane_signed = (state_q == IDLE) ? cfg_signed : sgn_q;
        finish      = 1'b0;

        if (abort) begin
            // Any beat accepted alongside abort is dropped on purpose.
            state_d = IDLE;
            count_d = '0;
        end else if (accept) begin
            case (state_q)
                IDLE: begin
                    len_d = len_norm;
                    sgn_d = cfg_signed;
                    if (len_norm == CNT_W'(1)) begin
                        finish = 1'b1;
                    end else begin
                        lane_load = 1'b1;
                        count_d   = CNT_W'(1);
                        state_d   = ACCUM;
                    end
                end
                ACCUM: begin
                    if (count_q + CNT_W'(1) == len_q) begin
                        finish  = 1'b1;
                        count_d = '0;
                        state_d = IDLE;
                    end else begin
                        lane_update = 1'b1;
                        count_d     = count_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    count_d = '0;
                end
            endcase
        end

        // A new result can only load while the old one is gone or leaving.
        if (finish) begin
            out_valid_d = 1'b1;
            out_data_d  = lane_result;
        end else begin
            out_valid_d = take ? 1'b0 : out_valid;
            out_data_d  = out_data;
        end
    end

    // State, counter, latched config and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            count_q   <= '0;
            len_q     <= CNT_W'(1);
            sgn_q     <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            len_q     <= len_d;
            sgn_q     <= sgn_d;
            out_valid <= out_valid_d;
            out_data  <= out_data_d;
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        maxpool_lane #(
            .DATA_W(DATA_W)
        ) u_lane (
            .clk      (clk),
            .rst      (rst),
            .load     (lane_load),
            .update   (lane_update),
            .first    (lane_first),
            .is_signed(lane_signed),
            .din      (in_data[g*DATA_W +: DATA_W]),
            .result   (lane_result[g*DATA_W +: DATA_W])
        );
    end

endmodule

// File: tb/tb_maxpool_accum_qint.sv
// Self-checking bench for maxpool_accum_qint: directed windows with literal
// expectations plus a long randomized run, all compared every cycle against
// a window-of-beats reference model.
module tb_maxpool_accum_qint;

    localparam int DATA_W  = 8;
    localparam int LANES   = 4;
    localparam int WIN_MAX = 16;
    localparam int CNT_W   = 5;
    localparam int BUS_W   = LANES * DATA_W;

    logic             clk = 1'b0;
    logic             rst;
    logic [CNT_W-1:0] cfg_win_len;
    logic             cfg_signed;
    logic             abort;
    logic             in_valid;
    logic             in_ready;
    logic [BUS_W-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [BUS_W-1:0] out_data;
    logic             busy;

    int n_checks = 0;
    int n_fail   = 0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    maxpool_accum_qint #(
        .DATA_W (DATA_W),
        .LANES  (LANES),
        .WIN_MAX(WIN_MAX),
        .CNT_W  (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_win_len(cfg_win_len),
        .cfg_signed (cfg_signed),
        .abort      (abort),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .busy       (busy)
    );

    task automatic check(input string name, input logic [BUS_W-1:0] act,
                         input logic [BUS_W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [BUS_W-1:0] pk(input int a0, input int a1,
                                            input int a2, input int a3);
        logic [7:0] b0, b1, b2, b3;
        b0 = a0[7:0];
        b1 = a1[7:0];
        b2 = a2[7:0];
        b3 = a3[7:0];
        return {b3, b2, b1, b0};
    endfunction

    // ---------------- reference model + scoreboard ----------------
    logic [BUS_W-1:0] beats[$];
    logic [BUS_W-1:0] exp_q[$];
    int               m_len;
    logic             m_sgn;
    logic             m_ov;
    logic [BUS_W-1:0] m_od;
    bit               chk_en = 1'b0;

    function automatic logic [BUS_W-1:0] window_max();
        logic [BUS_W-1:0] res;
        logic [7:0]       e;
        int               best, v;
        res = '0;
        for (int l = 0; l < LANES; l++) begin
            best = 0;
            for (int b = 0; b < beats.size(); b++) begin
                e = beats[b][l*DATA_W +: DATA_W];
                v = m_sgn ? int'($signed(e)) : int'(e);
                if (b == 0 || v > best) best = v;
            end
`ifdef MAXPOOL_RELU_EN
            if (m_sgn && best < 0) best = 0;
`endif
            res[l*DATA_W +: DATA_W] = best[7:0];
        end
        return res;
    endfunction

    // Compare outputs, then advance the model with the inputs of the coming edge.
    always @(negedge clk) begin
        logic             acc, tk, newres;
        logic [BUS_W-1:0] res;
        int               cfg;
        if (chk_en) begin
            check("cyc_out_valid", out_valid, m_ov);
            check("cyc_out_data", out_data, m_od);
            check("cyc_in_ready", in_ready, !m_ov || out_ready);
            check("cyc_busy", busy, beats.size() != 0);
            if (out_valid && out_ready && !rst) begin
                if (exp_q.size() == 0) check("sb_unexpected_result", out_valid, 1'b0);
                else check("sb_result", out_data, exp_q.pop_front());
            end
        end
        if (rst) begin
            beats.delete();
            exp_q.delete();
            m_ov   = 1'b0;
            m_od   = '0;
            chk_en = 1'b1;
        end else if (chk_en) begin
            acc    = in_valid && (!m_ov || out_ready);
            tk     = m_ov && out_ready;
            newres = 1'b0;
            res    = '0;
            if (abort) begin
                beats.delete();
            end else if (acc) begin
                if (beats.size() == 0) begin
                    cfg   = int'(cfg_win_len);
                    m_len = (cfg == 0) ? 1 : (cfg > WIN_MAX) ? WIN_MAX : cfg;
                    m_sgn = cfg_signed;
                end
                beats.push_back(in_data);
                if (beats.size() == m_len) begin
                    res = window_max();
                    beats.delete();
                    newres = 1'b1;
                end
            end
            if (newres) begin
                m_ov = 1'b1;
                m_od = res;
                exp_q.push_back(res);
            end else if (tk) begin
                m_ov = 1'b0;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one beat and hold it until it is accepted (bounded).
    task automatic send(input logic [BUS_W-1:0] d);
        logic ok;
        int   g;
        ok = 1'b0;
        g  = 0;
        in_valid = 1'b1;
        in_data  = d;
        while (!ok && g < 200) begin
            @(negedge clk);
            ok = in_ready;
            step();
            g++;
        end
        if (!ok) check("send_accept_timeout", ok, 1'b1);
        in_valid = 1'b0;
    endtask

    // Result must already be valid in the cycle after the last beat.
    task automatic expect_now(input string name, input logic [BUS_W-1:0] exp);
        @(negedge clk);
        check({name, "_valid"}, out_valid, 1'b1);
        check(name, out_data, exp);
        step();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [BUS_W-1:0] d, prev;
        rst = 1'b1; cfg_win_len = '0; cfg_signed = 1'b0; abort = 1'b0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        repeat (3) step();
        rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_data", out_data, '0);
        check("rst_busy", busy, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);
        step();

        // Unsigned window of three, result held under back-pressure.
        cfg_win_len = 5'd3; cfg_signed = 1'b0; out_ready = 1'b0;
        send(pk(1, 2, 3, 4));
        send(pk(9, 0, 3, 1));
        send(pk(5, 5, 200, 2));
        expect_now("t1_result", pk(9, 5, 200, 4));
        repeat (3) begin
            @(negedge clk);
            check("t1_hold", out_valid, 1'b1);
            step();
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("t1_ready_follows", in_ready, 1'b1);
        step();
        @(negedge clk);
        check("t1_taken", out_valid, 1'b0);
        step();

        // Signed versus unsigned on the same two beats.
        cfg_win_len = 5'd2; cfg_signed = 1'b1;
        send(pk(8'h80, 8'hFF, 8'h7F, 8'h01));
        send(pk(8'h01, 8'hFE, 8'h00, 8'h81));
`ifdef MAXPOOL_RELU_EN
        expect_now("t2_signed", pk(8'h01, 8'h00, 8'h7F, 8'h01));
`else
        expect_now("t2_signed", pk(8'h01, 8'hFF, 8'h7F, 8'h01));
`endif
        cfg_signed = 1'b0;
        send(pk(8'h80, 8'hFF, 8'h7F, 8'h01));
        send(pk(8'h01, 8'hFE, 8'h00, 8'h81));
        expect_now("t2_unsigned", pk(8'h80, 8'hFF, 8'h7F, 8'h81));

        // Window of one (and zero): echo every beat next cycle, no bubbles.
        for (int w = 1; w >= 0; w--) begin
            cfg_win_len = CNT_W'(w);
            prev = '0;
            for (int i = 0; i < 8; i++) begin
                d = $urandom;
                in_valid = 1'b1;
                in_data  = d;
                @(negedge clk);
                check("t3_in_ready", in_ready, 1'b1);
                if (i > 0) begin
                    check("t3_echo_valid", out_valid, 1'b1);
                    check("t3_echo", out_data, prev);
                end
                step();
                prev = d;
            end
            in_valid = 1'b0;
            expect_now("t3_echo_last", prev);
        end

        // Back-pressure: stalled input ignored, second window intact.
        cfg_win_len = 5'd2; cfg_signed = 1'b0; out_ready = 1'b0;
        send(pk(10, 20, 30, 40));
        send(pk(50, 1, 2, 3));
        in_valid = 1'b1;
        repeat (3) begin
            in_data = $urandom;
            @(negedge clk);
            check("t4_stall", in_ready, 1'b0);
            check("t4_pending", out_data, pk(50, 20, 30, 40));
            step();
        end
        out_ready = 1'b1;
        send(pk(7, 8, 9, 10));
        send(pk(1, 100, 2, 200));
        expect_now("t4_second", pk(7, 100, 9, 200));

        // Abort after two of four beats, with a beat offered during the abort.
        cfg_win_len = 5'd4;
        send(pk(200, 150, 250, 99));
        send(pk(180, 210, 17, 240));
        @(negedge clk);
        check("t5_busy_before", busy, 1'b1);
        step();
        abort = 1'b1; in_valid = 1'b1; in_data = pk(255, 255, 255, 255);
        step();
        abort = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check("t5_busy_after", busy, 1'b0);
        check("t5_no_result", out_valid, 1'b0);
        step();
        repeat (4) send(pk(3, 3, 3, 3));
        expect_now("t5_result", pk(3, 3, 3, 3));

        // All-negative signed window (clamped to zero when ReLU is built in).
        cfg_win_len = 5'd2; cfg_signed = 1'b1;
        send(pk(8'hF0, 8'hF0, 8'hF0, 8'hF0));
        send(pk(8'hE0, 8'h81, 8'hF0, 8'h80));
`ifdef MAXPOOL_RELU_EN
        expect_now("t6_relu", pk(0, 0, 0, 0));
`else
        expect_now("t6_relu", pk(8'hF0, 8'hF0, 8'hF0, 8'hF0));
`endif

        // Oversize window length saturates to WIN_MAX beats.
        cfg_win_len = 5'd31; cfg_signed = 1'b0;
        for (int i = 0; i < WIN_MAX; i++) send(pk(i, 15 - i, i, 15 - i));
        expect_now("t7_saturate", pk(15, 15, 15, 15));

        // Reset mid-window drops the partial window.
        cfg_win_len = 5'd3;
        send(pk(1, 1, 1, 1));
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        check("t8_rst_busy", busy, 1'b0);
        check("t8_rst_valid", out_valid, 1'b0);
        step();

        // Randomized traffic, config churn, aborts and occasional resets.
        for (int c = 0; c < 3000; c++) begin
            in_valid    = ($urandom_range(0, 3) != 0);
            in_data     = $urandom;
            out_ready   = ($urandom_range(0, 3) != 0);
            cfg_win_len = ($urandom_range(0, 9) == 0) ? CNT_W'($urandom_range(0, 31))
                                                      : CNT_W'($urandom_range(0, 5));
            cfg_signed  = $urandom_range(0, 1);
            abort       = ($urandom_range(0, 40) == 0);
            rst         = ($urandom_range(0, 500) == 0);
            step();
        end
        in_valid = 1'b0; abort = 1'b0; rst = 1'b0; out_ready = 1'b1;
        repeat (4) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
